// File: rtl/ram32x4_access_ctrl_if.sv
// Client-side request/response bundle for the 32x4 RAM access controller.
// The controller plays the slave; client logic (UI, display) is the master.
interface ram32x4_access_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              fill_done;

    modport master (
        output req_valid, req_op, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data, fill_done
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data, fill_done
    );
endinterface

// File: rtl/ram32x4_access_ctrl.sv
// Front end owning the 32x4 RAM ports: single read/write and whole-array
// fill commands, hiding the RAM's one-cycle registered read latency.
module ram32x4_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    ram32x4_access_ctrl_if.slave   bus,
    output logic                   busy,
    output logic [ADDR_W-1:0]      ram_address,
    output logic [DATA_W-1:0]      ram_data_in,
    output logic                   ram_write_enable,
    input  logic [DATA_W-1:0]      ram_data_out
);
    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_CAP,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d;
    logic              we_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              fill_done_q, fill_done_d;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.fill_done = fill_done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = ram_address;
        din_d       = ram_data_in;
        we_d        = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        fill_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_RD: begin
                            addr_d  = bus.req_addr;
                            state_d = RD_WAIT;
                        end
                        OP_WR: begin
                            addr_d  = bus.req_addr;
                            din_d   = bus.req_data;
                            we_d    = 1'b1;
                            state_d = WRITE;
                        end
                        OP_FILL: begin
                            addr_d  = '0;
                            din_d   = bus.req_data;
                            we_d    = 1'b1;
                            state_d = FILL;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WRITE:   state_d = IDLE;
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                rsp_data_d  = ram_data_out;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            FILL: begin
                // ram_address doubles as the fill counter
                if (ram_address == LAST) begin
                    addr_d      = '0;
                    fill_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    addr_d = ram_address + 1'b1;
                    we_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            rsp_data_q       <= '0;
            rsp_valid_q      <= 1'b0;
            fill_done_q      <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            ram_address      <= addr_d;
            ram_data_in      <= din_d;
            ram_write_enable <= we_d;
            rsp_data_q       <= rsp_data_d;
            rsp_valid_q      <= rsp_valid_d;
            fill_done_q      <= fill_done_d;
            busy             <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_ram32x4_access_ctrl.sv
// Bench for ram32x4_access_ctrl: directed scenarios plus random ops,
// checked against a shadow memory and transaction-level counters.
module tb_ram32x4_access_ctrl;
    localparam int AW = 5;
    localparam int DW = 4;
    localparam int DEPTH = 32;
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    ram32x4_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram32x4_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .busy             (busy),
        .ram_address      (addr),
        .ram_data_in      (din),
        .ram_write_enable (we),
        .ram_data_out     (dout)
    );

    always #5 clk = ~clk;

    // behavioural 32x4 synchronous RAM, registered read
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (we) mem[addr] <= din;
        ram_q <= mem[addr];
    end
    assign dout = ram_q;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_mem [DEPTH];
    int exp_we = 0;
    int exp_fd = 0;
    int n_reads = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;
    int fd_cnt = 0;
    int viol = 0;

    always @(posedge clk) begin
        #1;
        if (we) we_cnt++;
        if (bus.rsp_valid) rsp_cnt++;
        if (bus.fill_done) fd_cnt++;
        if (bus.rsp_valid && bus.fill_done) viol++;
        if (we && !busy) viol++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a request and hold it until accepted; w = cycles waited
    task automatic send(input logic [1:0] op, input int a, input int d,
                        output int w);
        w = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = AW'(a);
        bus.req_data  = DW'(d);
        @(negedge clk);
        while (!bus.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) chk("accept_timeout", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'(($urandom));
        bus.req_addr  = AW'($urandom);
        bus.req_data  = DW'($urandom);
    endtask

    task automatic do_write(input int a, input int d, output int w);
        send(OP_WR, a, d, w);
        chk("wr_we_on", 32'(we), 1);
        chk("wr_addr", 32'(addr), a);
        chk("wr_din", 32'(din), d);
        tick();
        chk("wr_we_off", 32'(we), 0);
        ref_mem[a] = d;
        exp_we += 1;
    endtask

    task automatic do_read(input int a, output int w);
        int lat;
        int got;
        send(OP_RD, a, $urandom, w);
        lat = 0;
        got = -1;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            tick();
            if (bus.rsp_valid) begin
                lat = k;
                got = 32'(bus.rsp_data);
            end
        end
        n_reads++;
        chk("rd_latency", lat, 2);
        chk($sformatf("rd_data[%0d]", a), got, ref_mem[a]);
    endtask

    task automatic do_fill(input int v);
        int w;
        int cyc;
        int early;
        send(OP_FILL, 0, v, w);
        cyc = 0;
        early = 0;
        for (int k = 1; k <= 40 && cyc == 0; k++) begin
            tick();
            if (bus.fill_done) cyc = k;
            else if (bus.req_ready) early++;
        end
        chk("fill_latency", cyc, 32);
        chk("fill_ready_low", early, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = v;
        exp_we += DEPTH;
        exp_fd += 1;
    endtask

    task automatic read_all();
        int w;
        for (int i = 0; i < DEPTH; i++) do_read(i, w);
    endtask

    initial begin
        int w;
        int r;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_RD;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(we), 0);
        reset = 1'b0;
        tick();
        chk("idle_outputs", 32'({addr, din, bus.rsp_data}), 0);
        chk("idle_strobes", 32'({bus.rsp_valid, bus.fill_done, busy}), 0);
        chk("idle_ready", 32'(bus.req_ready), 1);

        do_write(5'h0A, 4'hA, w);
        do_read(5'h0A, w);
        do_read(5'h0A, w);
        chk("b2b_read_wait", w, 0);

        send(OP_RSV, 5'h1F, 4'h5, w);
        chk("rsv_wait", w, 0);
        chk("rsv_no_we", 32'(we), 0);
        chk("rsv_busy", 32'(busy), 0);
        tick();
        chk("rsv_ready", 32'(bus.req_ready), 1);

        do_fill(4'h6);
        do_read(0, w);
        do_read(17, w);
        do_read(31, w);

        // write held while a fill is running
        send(OP_FILL, 0, 4'h5, w);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 4'h5;
        exp_we += DEPTH;
        exp_fd += 1;
        do_write(5'h03, 4'h9, w);
        chk("held_wait", w, 32);
        read_all();

        // fill cut short by reset after 10 writes
        send(OP_FILL, 0, 4'hC, w);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) ref_mem[i] = 4'hC;
        exp_we += 10;
        chk("abort_ready", 32'(bus.req_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_we", 32'(we), 0);
        chk("abort_addr", 32'(addr), 0);
        repeat (40) tick();
        read_all();

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 19);
            if (r < 8) do_read($urandom_range(0, DEPTH - 1), w);
            else if (r < 16)
                do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), w);
            else if (r < 17) do_fill($urandom_range(0, 15));
            else send(OP_RSV, $urandom_range(0, DEPTH - 1), 0, w);
            repeat ($urandom_range(0, 2)) tick();
        end
        read_all();

        repeat (3) tick();
        chk("we_cycles", we_cnt, exp_we);
        chk("rsp_pulses", rsp_cnt, n_reads);
        chk("fill_pulses", fd_cnt, exp_fd);
        chk("invariants", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
